// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Transmit scheduler for the node's single UART transmitter. Two requesters
// share it: the local operator (push button + switch word) and the ring relay
// path (received frames whose destination ID is not this node). Frames for
// this node go to the display path as a msg pulse and are not relayed.
// Relay frames are buffered in a small FIFO. When both sources are waiting,
// the grant alternates between them. Every frame is handed over to the
// transmitter with a start/busy handshake and followed by a fixed idle gap.
//
// Ports
//   clk            system clock (single clock domain)
//   reset          asynchronous, active-high reset
//   send           raw push button, asynchronous to clk
//   local_data     switch word captured on a send edge
//   my_id          this node's ID
//   rx_valid       one-cycle pulse: rx_data holds a new received frame
//   rx_data        received frame; [5:4] is the destination ID
//   tx_busy        transmitter busy flag
//   tx_start       one-cycle pulse: transmitter loads tx_data
//   tx_data        frame to transmit (held from one grant to the next)
//   tx_src         source of the current/last grant: 0 local, 1 relay
//   local_pending  a local frame is waiting
//   fifo_count     relay entries held
//   drop_count     relay frames dropped on overflow (saturates at 255)
//   msg_valid      one-cycle pulse: a frame for this node was received
//   msg_data       last frame for this node
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int GAP_CYCLES = 16   // >= 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          send,
  input  logic [7:0]                    local_data,
  input  logic [1:0]                    my_id,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic                          tx_src,
  output logic                          local_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic                          msg_valid,
  output logic [7:0]                    msg_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(GAP_CYCLES + 4);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  // The transmitter gets four cycles to raise tx_busy before the frame is
  // assumed sent.
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(3);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // send synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic send_edge;

  // NOTE: sequential state is assigned with non-blocking (<=) so that every
  // flop samples the values from before the clock edge, independent of the
  // statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= send;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign send_edge = sync2_q & ~sync3_q;

  // ---------------------------------------------------------------------------
  // Receive classification
  // ---------------------------------------------------------------------------
  logic rx_mine, rx_relay;

  assign rx_mine  = rx_valid && (rx_data[5:4] == my_id);
  assign rx_relay = rx_valid && (rx_data[5:4] != my_id);

  // ---------------------------------------------------------------------------
  // Relay FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full, relay_req;
  logic             push, pop, drop;
  logic             grant_local, grant_relay;

  assign fifo_full = (count_q == FULL_CNT);
  assign relay_req = (count_q != '0);
  assign pop       = grant_relay;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still
  // succeeds in that case.
  assign push      = rx_relay && (!fifo_full || pop);
  assign drop      = rx_relay && fifo_full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; only the pointers and the count
  // define which entries are valid, so resetting the data would add wiring
  // for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // The FIFO depth is a power of 2, so the pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: arbitration, start pulse, handshake, inter-frame gap
  // ---------------------------------------------------------------------------
  logic last_src_q;
  logic local_pending_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_local = 1'b0;
    grant_relay = 1'b0;
    tx_start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A local grant needs either no relay request or a relay grant last
        // time. Otherwise the relay side wins if it has anything.
        if (local_pending_q && (!relay_req || last_src_q)) begin
          grant_local = 1'b1;
        end else if (relay_req) begin
          grant_relay = 1'b1;
        end
        if (grant_local || grant_relay) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_WAIT_ACK;
        cnt_d    = '0;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Local request register, grant datapath, msg path and drop counter
  // ---------------------------------------------------------------------------
  logic [7:0] local_q;
  logic [7:0] tx_data_q;
  logic       tx_src_q;
  logic       msg_valid_q;
  logic [7:0] msg_data_q;
  logic [7:0] drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      local_q         <= '0;
      local_pending_q <= 1'b0;
      tx_data_q       <= '0;
      tx_src_q        <= 1'b0;
      // Reset to "relay" so local wins the first tie.
      last_src_q      <= 1'b1;
      msg_valid_q     <= 1'b0;
      msg_data_q      <= '0;
      drop_q          <= '0;
    end else begin
      // A send edge that arrives while a frame is already pending is ignored,
      // including in the cycle that grants that pending frame.
      if (grant_local) begin
        local_pending_q <= 1'b0;
      end else if (send_edge && !local_pending_q) begin
        local_pending_q <= 1'b1;
        local_q         <= local_data;
      end

      if (grant_local || grant_relay) begin
        tx_data_q  <= grant_local ? local_q : mem_q[rd_ptr_q];
        tx_src_q   <= grant_relay;
        last_src_q <= grant_relay;
      end

      msg_valid_q <= rx_mine;
      if (rx_mine) begin
        msg_data_q <= rx_data;
      end

      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_src        = tx_src_q;
  assign local_pending = local_pending_q;
  assign fifo_count    = count_q;
  assign drop_count    = drop_q;
  assign msg_valid     = msg_valid_q;
  assign msg_data      = msg_data_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler for the node's single UART transmitter. It shares the transmitter between two requesters: the local operator (push button plus 8-bit switch word) and the ring relay path (received frames whose ID field does not match this node). Frames addressed to this node are diverted to the display path instead of being relayed. The block sits between the receiver/ID comparator and the transmitter, and replaces the fixed switch/relay mux with a buffered, fair, handshaked sequencer.

## Interface
Parameters:
- FIFO_DEPTH, 4, relay buffer entries; must be a power of 2, minimum 2.
- GAP_CYCLES, 16, idle clk cycles enforced between the end of one frame and the next tx_start; minimum 1.

Ports:
- clk  in  1  system clock; the single clock.
- reset  in  1  asynchronous, active-high reset.
- send  in  1  raw push button, asynchronous to clk.
- local_data  in  8  switch word.
- my_id  in  2  this node's ID.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new received frame.
- rx_data  in  8  received frame; bits [5:4] are the destination ID.
- tx_busy  in  1  transmitter busy flag.
- tx_start  out  1  one-cycle pulse: the transmitter must load tx_data.
- tx_data  out  8  frame to transmit.
- tx_src  out  1  source of the current/last grant: 0 = local, 1 = relay.
- local_pending  out  1  a local frame is waiting.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  relay entries held.
- drop_count  out  8  relay frames dropped; saturates at 255.
- msg_valid  out  1  one-cycle pulse: a frame for this node was received.
- msg_data  out  8  last frame for this node.

## Operation
- All outputs reset to 0. The FSM resets to IDLE, the FIFO empties, and last_src resets to 1 (relay) so that local wins the first tie.
- **send input:** synchronised by 2 flops, then rising-edge detected.
  - Edge with local_pending=0: local_data is captured into the local register and local_pending is set.
  - Edge with local_pending=1: ignored; the captured data is unchanged.
- **rx_valid with rx_data[5:4]==my_id:** msg_data<=rx_data and msg_valid pulses; nothing is pushed.
- **rx_valid with a mismatched ID, FIFO not full:** the frame is pushed.
- **rx_valid with a mismatched ID, FIFO full:** the frame is dropped and drop_count increments (saturating), unless a pop occurs in the same cycle. A same-cycle pop makes room, so the push succeeds and the count is unchanged.
- **Arbitration:** evaluated only in IDLE.
  - Requests: L = local_pending, R = fifo_count!=0.
  - Only one of L/R set: that source is granted.
  - Both set: the source opposite to last_src is granted (round robin).
- **Grant:** tx_data is loaded from the local register or the FIFO head, tx_src and last_src are updated, and the FSM goes to START.
  - Local grant: local_pending is cleared.
  - Relay grant: the FIFO is popped.
- **FSM states:**
  - IDLE: arbitrate. Go to START on a grant.
  - START: tx_start=1 for exactly this cycle. Go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy stays 0 for 4 cycles, treat the frame as sent and go to GAP.
  - WAIT_DONE: wait for tx_busy=0, then go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- tx_data is held stable from the grant until the next grant.
- Pushes and msg handling continue in every state.
- **Reset mid-frame:** all state and outputs return to 0 immediately. The transmitter is not aborted by this block.

## Timing
- **send latency:** edge at the pin → local_pending=1 three clk edges later (2 sync flops plus the edge register).
- **rx_valid at cycle n:**
  - fifo_count is updated at n+1.
  - For a matching ID, msg_valid=1 during n+1.
- **Grant:** IDLE with a request at cycle n → tx_data valid at n+1 and tx_start=1 during n+1.
- **Frame spacing:** from tx_busy falling at cycle m, the earliest next tx_start is at cycle m+GAP_CYCLES+2.
- **FIFO pointers:** wrap modulo FIFO_DEPTH.
- **FIFO push/pop order:** simultaneous push and pop are both honoured in the same cycle, including when full and when empty-plus-push. A pop requires an entry present at the start of that cycle.

## Test plan
- **Local only:** reset; local_data=0xA5, one send pulse → one tx_start, tx_data=0xA5, tx_src=0, local_pending back to 0. The transmitter model holds tx_busy for 10 cycles and no further tx_start occurs.
- **Own frame:** my_id=2, rx_valid with rx_data=0x2C (ID 2) → msg_valid pulse, msg_data=0x2C, fifo_count stays 0, no tx_start.
- **Round robin:** with local_pending=1 and 3 relay frames 0x11, 0x12, 0x13 queued (ID≠my_id) → transmitted order is local, 0x11, 0x12, 0x13. Consecutive tx_start pulses are at least GAP_CYCLES+2 cycles after each tx_busy fall.
- **Overflow:** with the FSM held in WAIT_DONE (tx_busy=1), push 6 mismatched frames → fifo_count=4, drop_count=2. Then release tx_busy → the first 4 frames are sent in order.
- **Ack timeout:** tx_busy is never raised → after tx_start, the FSM passes through GAP to IDLE and the next queued frame is granted.
- **Reset mid-operation:** assert reset in WAIT_DONE with 2 frames queued → all outputs are 0 immediately, fifo_count=0, and no tx_start occurs after reset is released.
